fir_error_stats: RTL and testbench
==================================

Name: fir_error_stats

Overview:
- Streaming error-statistics collector placed directly downstream of the approximate/accurate FIR pair.
- Each accepted beat carries the approximate output and the accurate output for one sample.
- The block accumulates, over a programmed number of samples:
  - error sum,
  - error-squared sum,
  - absolute-accurate-output sum.
- Software or a bench derives mean, variance, std and relative error from the final totals.

Parameters:
DATA_W, 32, width of the signed FIR outputs
CNT_W, 32, width of the sample counter and test_size
ACC_W, 64, width of err_sum and abs_sum
SQ_W, 96, width of err_sq_sum

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; clears accumulators and loads test_size
test_size  in  CNT_W  number of samples to collect, unsigned
in_valid  in  1  appr/accu beat valid
in_ready  out  1  block can accept a beat
appr  in  DATA_W  signed approximate FIR output
accu  in  DATA_W  signed accurate FIR output
busy  out  1  FSM in RUN or DRAIN
done  out  1  totals final; held until next start
sample_cnt  out  CNT_W  beats accepted since start
err_sum  out  ACC_W  signed sum of (appr - accu)
err_sq_sum  out  SQ_W  unsigned sum of (appr - accu)^2
abs_sum  out  ACC_W  unsigned sum of |accu|
overflow  out  1  sticky; any accumulator wrapped since start

Behaviour:
Clock and reset:
- One clock, clk.
- Reset rst is asynchronous and active-high.
- While rst is high, all outputs are 0 and the FSM is in IDLE. This applies mid-run too: no partial totals survive.

FSM states:
- IDLE: in_ready=0, busy=0, done=0.
- RUN: in_ready=1, busy=1.
- DRAIN: in_ready=0, busy=1.
- DONE: in_ready=0, busy=0, done=1.

Transitions:
- IDLE or DONE, start=1:
  - Clear sample_cnt, err_sum, err_sq_sum, abs_sum and overflow.
  - Latch test_size.
  - Go to RUN; if test_size==0, go straight to DONE with all totals 0.
- start in RUN or DRAIN is ignored.
- RUN: a beat is accepted when in_valid and in_ready. Each accept increments sample_cnt.
  - On the accept that makes sample_cnt equal the latched size, go to DRAIN.
  - in_ready is deasserted the cycle after that final accept.
- DRAIN: exactly 2 cycles, then DONE.
- DONE: holds totals until the next start.

Pipeline (2 stages, no stalls):
- Stage 1 registers:
  - err = appr - accu, computed at DATA_W+1 bits signed;
  - mag = |accu|, at DATA_W+1 bits unsigned. For accu = -2^(DATA_W-1), mag = 2^(DATA_W-1).
- Stage 2 computes:
  - err_sum += sign-extended err;
  - err_sq_sum += err*err (2*DATA_W+2 bits, zero-extended);
  - abs_sum += mag.
- Accumulator visibility: totals reflect beat k two cycles after its accept.
- done rises in the same cycle the last beat's contribution is visible.

Overflow:
- Accumulators wrap modulo 2^width.
- overflow is set on a signed overflow of err_sum, or an unsigned carry-out of err_sq_sum or abs_sum.
- overflow is sticky until start or rst.

Other rules:
- sample_cnt never exceeds the latched size.
- in_valid while in_ready=0 is not consumed and has no effect.

Decomposition:
- Package fir_stats_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - default width constants DATA_W, ACC_W, SQ_W, CNT_W;
  - DRAIN_CYCLES = 2.
- One natural sub-module, fir_err_stage: the stage-1 register computing err and mag with a valid bit.
- FSM, counter and accumulators stay in the top.

Test Plan:
1. test_size=3; beats (appr,accu) = (10,7), (5,9), (-4,-4), in_valid held high → in_ready high for 3 cycles. Final totals: err_sum=-1, err_sq_sum=25, abs_sum=20, sample_cnt=3, overflow=0. done asserts 2 cycles after the third accept.
2. test_size=0 with start → done=1 on the next cycle; all totals 0; in_ready never asserts.
3. test_size=2; beats (0,-2^31) and (2^31-1,-2^31) → err_sum=2^31+(2^32-1)=6442450943; abs_sum=2^32; err_sq_sum=2^62+(2^32-1)^2; overflow=0.
4. test_size=4; in_valid toggles 1,0,0,1,1,0,1, with a start pulse inserted mid-RUN → start ignored; sample_cnt advances only on handshakes; done after the 4th accept plus 2 cycles.
5. rst asserted asynchronously after 2 of 5 beats (between clock edges) → all outputs 0 immediately. A new start with test_size=1 and beat (3,1) gives err_sum=2, err_sq_sum=4, abs_sum=1.
6. ACC_W=34; test_size=3; beats (2^31-1, -2^31) ×3 → err_sum wraps and overflow=1, stays 1 through DONE, and clears on the next start.

Source files
------------

// File: rtl/fir_stats_pkg.sv
// Shared widths, drain length and FSM state type for the FIR error-statistics collector.
package fir_stats_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned CNT_W        = 32;
  localparam int unsigned ACC_W        = 64;
  localparam int unsigned SQ_W         = 96;
  localparam int unsigned DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/fir_err_stage.sv
// Stage-1 register: error (appr - accu) and |accu|, both one bit wider than the inputs.
module fir_err_stage #(
  parameter int unsigned DATA_W = fir_stats_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] appr_i,
  input  logic [DATA_W-1:0] accu_i,
  output logic              valid_o,
  output logic [DATA_W:0]   err_o,
  output logic [DATA_W:0]   mag_o
);

  logic [DATA_W:0] appr_ext, accu_ext, err_d, mag_d;
  logic [DATA_W:0] err_q, mag_q;
  logic            valid_q;

  always_comb begin
    appr_ext = {appr_i[DATA_W-1], appr_i};
    accu_ext = {accu_i[DATA_W-1], accu_i};
    err_d    = appr_ext - accu_ext;
    // The extra bit lets |-2^(DATA_W-1)| be represented exactly.
    mag_d    = accu_ext[DATA_W] ? (~accu_ext + 1'b1) : accu_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      err_q   <= '0;
      mag_q   <= '0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        err_q <= err_d;
        mag_q <= mag_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign mag_o   = mag_q;

endmodule

// File: rtl/fir_error_stats.sv
// Accumulates error, squared-error and |accurate| sums over a programmed sample count.
module fir_error_stats #(
  parameter int unsigned DATA_W = fir_stats_pkg::DATA_W,
  parameter int unsigned CNT_W  = fir_stats_pkg::CNT_W,
  parameter int unsigned ACC_W  = fir_stats_pkg::ACC_W,
  parameter int unsigned SQ_W   = fir_stats_pkg::SQ_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  test_size,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] appr,
  input  logic [DATA_W-1:0] accu,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [ACC_W-1:0]  err_sum,
  output logic [SQ_W-1:0]   err_sq_sum,
  output logic [ACC_W-1:0]  abs_sum,
  output logic              overflow
);

  import fir_stats_pkg::*;

  // The final accept cycle is the first pipeline cycle, so DRAIN itself covers the rest.
  localparam logic [1:0] DrainLoad = 2'(DRAIN_CYCLES - 2);

  state_e           state_q;
  logic [CNT_W-1:0] size_q, cnt_q, cnt_inc;
  logic [1:0]       drain_q;
  logic             in_ready_q, busy_q, done_q;
  logic             accept, start_ok;

  logic              st_valid;
  logic [DATA_W:0]   st_err, st_mag;
  logic [ACC_W-1:0]  err_sum_q, abs_sum_q, err_ext, err_sum_d;
  logic [SQ_W-1:0]   err_sq_sum_q;
  logic [2*DATA_W+1:0] err_wide, sq;
  logic [SQ_W:0]     sq_sum_full;
  logic [ACC_W:0]    abs_sum_full;
  logic              err_ovf, overflow_q;

  assign accept   = in_valid && in_ready_q;
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign cnt_inc  = cnt_q + 1'b1;

  fir_err_stage #(
    .DATA_W (DATA_W)
  ) u_err_stage (
    .clk     (clk),
    .rst     (rst),
    .valid_i (accept),
    .appr_i  (appr),
    .accu_i  (accu),
    .valid_o (st_valid),
    .err_o   (st_err),
    .mag_o   (st_mag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      size_q     <= '0;
      cnt_q      <= '0;
      drain_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            size_q <= test_size;
            cnt_q  <= '0;
            if (test_size == '0) begin
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == size_q) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
              drain_q    <= DrainLoad;
            end
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    err_ext      = {{(ACC_W-DATA_W-1){st_err[DATA_W]}}, st_err};
    err_sum_d    = err_sum_q + err_ext;
    err_wide     = {{(DATA_W+1){st_err[DATA_W]}}, st_err};
    sq           = err_wide * err_wide;
    sq_sum_full  = {1'b0, err_sq_sum_q} + {{(SQ_W-2*DATA_W-1){1'b0}}, sq};
    abs_sum_full = {1'b0, abs_sum_q} + {{(ACC_W-DATA_W){1'b0}}, st_mag};
    err_ovf      = (err_sum_q[ACC_W-1] == err_ext[ACC_W-1]) &&
                   (err_sum_d[ACC_W-1] != err_sum_q[ACC_W-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sum_q    <= '0;
      err_sq_sum_q <= '0;
      abs_sum_q    <= '0;
      overflow_q   <= 1'b0;
    end else if (start_ok) begin
      err_sum_q    <= '0;
      err_sq_sum_q <= '0;
      abs_sum_q    <= '0;
      overflow_q   <= 1'b0;
    end else if (st_valid) begin
      err_sum_q    <= err_sum_d;
      err_sq_sum_q <= sq_sum_full[SQ_W-1:0];
      abs_sum_q    <= abs_sum_full[ACC_W-1:0];
      overflow_q   <= overflow_q | err_ovf | sq_sum_full[SQ_W] | abs_sum_full[ACC_W];
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_cnt = cnt_q;
  assign err_sum    = err_sum_q;
  assign err_sq_sum = err_sq_sum_q;
  assign abs_sum    = abs_sum_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fir_error_stats.sv
// Directed bench: default-width instance plus a 34-bit accumulator instance sharing stimulus.
module tb_fir_error_stats;

  logic        clk, rst, start, in_valid;
  logic [31:0] test_size, appr, accu;

  logic        a_in_ready, a_busy, a_done, a_ovf;
  logic [31:0] a_cnt;
  logic [63:0] a_err_sum, a_abs_sum;
  logic [95:0] a_sq_sum;

  logic        b_in_ready, b_busy, b_done, b_ovf;
  logic [31:0] b_cnt;
  logic [33:0] b_err_sum, b_abs_sum;
  logic [95:0] b_sq_sum;

  int n_pass   = 0;
  int n_checks = 0;

  fir_error_stats u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .test_size  (test_size),
    .in_valid   (in_valid),
    .in_ready   (a_in_ready),
    .appr       (appr),
    .accu       (accu),
    .busy       (a_busy),
    .done       (a_done),
    .sample_cnt (a_cnt),
    .err_sum    (a_err_sum),
    .err_sq_sum (a_sq_sum),
    .abs_sum    (a_abs_sum),
    .overflow   (a_ovf)
  );

  fir_error_stats #(
    .ACC_W (34)
  ) u_dut34 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .test_size  (test_size),
    .in_valid   (in_valid),
    .in_ready   (b_in_ready),
    .appr       (appr),
    .accu       (accu),
    .busy       (b_busy),
    .done       (b_done),
    .sample_cnt (b_cnt),
    .err_sum    (b_err_sum),
    .err_sq_sum (b_sq_sum),
    .abs_sum    (b_abs_sum),
    .overflow   (b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] pat;
    int         exp_cnt [7];
    pat     = 7'b1011001;
    exp_cnt = '{1, 1, 1, 2, 3, 3, 4};

    rst = 1'b1; start = 1'b0; test_size = '0; in_valid = 1'b0; appr = '0; accu = '0;
    #12;
    check("rst_ready", a_in_ready, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_done", a_done, 1'b0);
    check("rst_err_sum", a_err_sum, '0);
    rst = 1'b0;
    tick();

    // 1: basic three-beat run
    start = 1'b1; test_size = 3; in_valid = 1'b1; appr = 10; accu = 7;
    tick();
    start = 1'b0;
    check("t1_ready", a_in_ready, 1'b1);
    check("t1_busy", a_busy, 1'b1);
    tick();
    check("t1_cnt1", a_cnt, 32'd1);
    appr = 5; accu = 9;
    tick();
    check("t1_cnt2", a_cnt, 32'd2);
    check("t1_err_partial", a_err_sum, 64'd3);
    appr = 32'hFFFF_FFFC; accu = 32'hFFFF_FFFC;
    tick();
    check("t1_cnt3", a_cnt, 32'd3);
    check("t1_ready_low", a_in_ready, 1'b0);
    check("t1_done_early", a_done, 1'b0);
    in_valid = 1'b0;
    tick();
    check("t1_done", a_done, 1'b1);
    check("t1_busy_low", a_busy, 1'b0);
    check("t1_err_sum", a_err_sum, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t1_sq_sum", a_sq_sum, 96'd25);
    check("t1_abs_sum", a_abs_sum, 64'd20);
    check("t1_ovf", a_ovf, 1'b0);

    // 2: zero-length run
    start = 1'b1; test_size = 0;
    tick();
    start = 1'b0;
    check("t2_done", a_done, 1'b1);
    check("t2_ready", a_in_ready, 1'b0);
    check("t2_cnt", a_cnt, 32'd0);
    check("t2_err_sum", a_err_sum, '0);
    check("t2_sq_sum", a_sq_sum, '0);
    check("t2_abs_sum", a_abs_sum, '0);
    tick();
    check("t2_ready_later", a_in_ready, 1'b0);

    // 3: extreme values
    start = 1'b1; test_size = 2; in_valid = 1'b1; appr = 32'd0; accu = 32'h8000_0000;
    tick();
    start = 1'b0;
    tick();
    appr = 32'h7FFF_FFFF;
    tick();
    in_valid = 1'b0;
    tick();
    check("t3_done", a_done, 1'b1);
    check("t3_err_sum", a_err_sum, 64'h0000_0001_7FFF_FFFF);
    check("t3_abs_sum", a_abs_sum, 64'h0000_0001_0000_0000);
    check("t3_sq_sum", a_sq_sum, 96'h1_3FFF_FFFE_0000_0001);
    check("t3_ovf", a_ovf, 1'b0);

    // 4: gapped handshakes with an ignored mid-run start
    start = 1'b1; test_size = 4; appr = 2; accu = 32'hFFFF_FFFF; in_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid  = pat[i];
      start     = (i == 2);
      test_size = (i == 2) ? 32'd9 : 32'd4;
      tick();
      start = 1'b0;
      check($sformatf("t4_cnt_%0d", i), a_cnt, 32'(exp_cnt[i]));
    end
    check("t4_ready_low", a_in_ready, 1'b0);
    check("t4_done_early", a_done, 1'b0);
    tick();
    check("t4_done", a_done, 1'b1);
    check("t4_err_sum", a_err_sum, 64'd12);
    check("t4_sq_sum", a_sq_sum, 96'd36);
    check("t4_abs_sum", a_abs_sum, 64'd4);
    tick();
    check("t4_cnt_hold", a_cnt, 32'd4);
    check("t4_err_hold", a_err_sum, 64'd12);
    in_valid = 1'b0;

    // 5: asynchronous reset mid-run, then a fresh one-beat run
    start = 1'b1; test_size = 5; appr = 1; accu = 0;
    tick();
    start = 1'b0; in_valid = 1'b1;
    tick();
    tick();
    check("t5_cnt_pre", a_cnt, 32'd2);
    check("t5_err_pre", a_err_sum, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_cnt", a_cnt, 32'd0);
    check("t5_rst_err", a_err_sum, '0);
    check("t5_rst_sq", a_sq_sum, '0);
    check("t5_rst_abs", a_abs_sum, '0);
    check("t5_rst_busy", a_busy, 1'b0);
    check("t5_rst_ready", a_in_ready, 1'b0);
    #2;
    in_valid = 1'b0; rst = 1'b0;
    start = 1'b1; test_size = 1; appr = 3; accu = 1; in_valid = 1'b1;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    check("t5_done", a_done, 1'b1);
    check("t5_err_sum", a_err_sum, 64'd2);
    check("t5_sq_sum", a_sq_sum, 96'd4);
    check("t5_abs_sum", a_abs_sum, 64'd1);

    // 6: 34-bit accumulator wraps
    start = 1'b1; test_size = 3; appr = 32'h7FFF_FFFF; accu = 32'h8000_0000; in_valid = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    check("t6_ovf_pre", b_ovf, 1'b0);
    check("t6_err_pre", b_err_sum, 34'h1_FFFF_FFFE);
    tick();
    check("t6_done", b_done, 1'b1);
    check("t6_ovf", b_ovf, 1'b1);
    check("t6_err_wrap", b_err_sum, 34'h2_FFFF_FFFD);
    check("t6_err_wide", a_err_sum, 64'h0000_0002_FFFF_FFFD);
    check("t6_ovf_wide", a_ovf, 1'b0);
    tick();
    tick();
    check("t6_ovf_sticky", b_ovf, 1'b1);
    start = 1'b1; test_size = 0;
    tick();
    start = 1'b0;
    check("t6_ovf_clr", b_ovf, 1'b0);
    check("t6_err_clr", b_err_sum, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
